pwm_multi: RTL
==============

Name: pwm_multi

Overview:
- Parametrised multi-channel PWM generator; successor to the fixed 8-LED, fixed-period PWM.
- One shared period counter drives CHANNELS compare outputs.
- Duty, period and alignment mode are runtime-programmable through a write port. New values are double-buffered and take effect only at a period boundary, so outputs never glitch.
- Sits between a register/control block and LED or motor-driver pins.

Parameters:
- CHANNELS, 8, number of PWM outputs (1..32).
- WIDTH, 9, counter/duty/period width in bits.
- DEFAULT_PERIOD, 500, active period value after reset.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable; low = counter held at 0, outputs low.
- mode_wr  in  1  write strobe for mode_in.
- mode_in  in  1  0 = edge-aligned, 1 = center-aligned.
- period_wr  in  1  write strobe for period_in.
- period_in  in  WIDTH  new period value P.
- duty_wr  in  1  write strobe for duty_in.
- duty_ch  in  $clog2(CHANNELS) (min 1)  target channel index.
- duty_in  in  WIDTH  new duty value D.
- pwm_out  out  CHANNELS  PWM outputs.
- period_tick  out  1  high during the last cycle of each period.

Behaviour:
- Reset (async assert, sync-safe deassert to first clk edge):
  - cnt=0, dir=up, mode=0.
  - Active and shadow period = DEFAULT_PERIOD.
  - All active and shadow duties = 0.
  - pwm_out = 0, period_tick = 0.
- State per field: a shadow register and an active register.
- Writes:
  - A strobe updates the shadow on that clock edge.
  - duty_ch >= CHANNELS: write ignored.
  - Simultaneous mode/period/duty writes are all accepted.
- Boundary load: all shadows copy to active on the edge that ends the cycle in which period_tick=1.
- Write on a boundary cycle: the written value goes straight into active as well as shadow (the write wins).
- Edge-aligned mode:
  - cnt sequence 0,1,..,P, then wrap to 0; period = P+1 cycles.
  - period_tick = (cnt==P).
- Center-aligned mode:
  - cnt sequence 0,1,..,P,P-1,..,1, then 0; period = 2P cycles; dir register tracks up/down.
  - Turnaround at cnt==P.
  - period_tick high on cnt==1 while counting down, or on cnt==P when P==1.
- P==0, either mode: cnt stays 0 and period_tick=1 every cycle (loads every cycle).
- Compare output:
  - pwm_out[i] = en_q & (cnt < duty_act[i]), decoded from registered state only. No combinational path from inputs to pwm_out.
  - Edge mode: high cycles per period = min(D, P+1). D=0 gives always low; D>P gives always high.
  - Center mode: high cycles = 2D-1 for 1<=D<=P, 2P for D>P, 0 for D=0. The pulse is symmetric around cnt==0.
- Enable:
  - en is registered (en_q).
  - While en_q=0: cnt=0, dir=up, pwm_out=0, period_tick=0, and shadows copy to active every cycle (writes apply immediately).
  - Rising en: counting starts from 0 on the cycle after en_q goes high.
- Mode switch: applies only at a boundary; cnt restarts at 0 with dir=up.
- Period shrink below the current cnt can only occur at a boundary, so cnt is never out of range.
- Arithmetic is unsigned WIDTH-bit. The counter never exceeds P, so there is no overflow.

Test Plan:
- Reset mid-run: assert rst with cnt=5 -> pwm_out=0, period_tick=0 immediately (async); after release with en=1 and P=500, first period_tick after 501 cycles.
- Edge mode, P=9, ch0 D=3, ch1 D=0, ch2 D=12 -> per 10-cycle period ch0 high 3 cycles, ch1 never high, ch2 always high; period_tick every 10 cycles.
- Center mode, P=4, ch0 D=2 -> 8-cycle period, ch0 high 3 contiguous cycles (cnt 1,0,1), period_tick on descending cnt==1.
- Double buffering: ch0 D=3 running at P=9, write D=7 at cnt=4 -> current period keeps 3 high cycles, next period 7. Write landing on the period_tick cycle takes effect in that very next period.
- en low mid-period: pwm_out and period_tick drop 1 cycle after en falls; write D=5 while disabled; on re-enable the first period already uses D=5.
- Corner cases:
  - P=0 -> period_tick constant high, pwm_out[i] = (D_i>0).
  - duty_ch=CHANNELS -> no channel changes.

Source files
------------

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator. One shared period counter drives
// CHANNELS compare outputs. Duty, period and alignment mode are double-buffered.
// New values move into the active set only at a period boundary, or on every
// cycle while the block is disabled.
module pwm_multi #(
   parameter int CHANNELS       = 8,
   parameter int WIDTH          = 9,
   parameter int DEFAULT_PERIOD = 500
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                mode_wr,
   input  logic                mode_in,
   input  logic                period_wr,
   input  logic [WIDTH-1:0]    period_in,
   input  logic                duty_wr,
   input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] duty_ch,
   input  logic [WIDTH-1:0]    duty_in,
   output logic [CHANNELS-1:0] pwm_out,
   output logic                period_tick
);

   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic             en_q;
   logic [WIDTH-1:0] cnt, cnt_nx;
   logic             dir, dir_nx;           // 0 = counting up, 1 = counting down
   logic             mode_sh, mode_act, mode_nx;
   logic [WIDTH-1:0] period_sh, period_act, period_nx;
   logic [WIDTH-1:0] duty_sh  [CHANNELS];
   logic [WIDTH-1:0] duty_act [CHANNELS];
   logic [WIDTH-1:0] duty_nx  [CHANNELS];
   logic             tick_raw;
   logic             load;

   // Shadow next-values: a strobe replaces the shadow, and out-of-range channels match nothing.
   always_comb begin
      mode_nx   = mode_wr   ? mode_in   : mode_sh;
      period_nx = period_wr ? period_in : period_sh;
      duty_nx   = duty_sh;
      for (int i = 0; i < CHANNELS; i++) begin
         if (duty_wr && (duty_ch == CH_W'(i))) begin
            duty_nx[i] = duty_in;
         end
      end
   end

   // Last cycle of the current period, from the active mode and period.
   always_comb begin
      tick_raw = 1'b0;
      if (period_act == '0) begin
         tick_raw = 1'b1;
      end else if (!mode_act) begin
         tick_raw = (cnt == period_act);
      end else begin
         tick_raw = (cnt == ONE) && (dir || (period_act == ONE));
      end
      load = !en_q || tick_raw;
   end

   // Counter next state: restart at every boundary (and while disabled), else step.
   always_comb begin
      cnt_nx = cnt;
      dir_nx = dir;
      if (load) begin
         cnt_nx = '0;
         dir_nx = 1'b0;
      end else if (!mode_act) begin
         cnt_nx = cnt + ONE;
      end else if (!dir) begin
         if (cnt == period_act) begin
            cnt_nx = cnt - ONE;
            dir_nx = 1'b1;
         end else begin
            cnt_nx = cnt + ONE;
         end
      end else begin
         cnt_nx = cnt - ONE;
      end
   end

   // Registered state: enable, counter, shadows, and boundary load of the active set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_q       <= 1'b0;
         cnt        <= '0;
         dir        <= 1'b0;
         mode_sh    <= 1'b0;
         mode_act   <= 1'b0;
         period_sh  <= WIDTH'(DEFAULT_PERIOD);
         period_act <= WIDTH'(DEFAULT_PERIOD);
         for (int i = 0; i < CHANNELS; i++) begin
            duty_sh[i]  <= '0;
            duty_act[i] <= '0;
         end
      end else begin
         en_q      <= en;
         cnt       <= cnt_nx;
         dir       <= dir_nx;
         mode_sh   <= mode_nx;
         period_sh <= period_nx;
         duty_sh   <= duty_nx;
         if (load) begin
            mode_act   <= mode_nx;
            period_act <= period_nx;
            duty_act   <= duty_nx;
         end
      end
   end

   // Compare outputs decoded purely from registered state.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         pwm_out[i] = en_q && (cnt < duty_act[i]);
      end
      period_tick = en_q && tick_raw;
   end

endmodule
